// File: rtl/cpu16_fetch_mem_ctrl.sv
// Fetch/decode/data-memory core of the 16-bit CPU: instruction memory, field decode, ALU control, data memory.
// Optional alignment flags are enabled with the CPU16_ALIGN_CHECK_EN macro.
module cpu16_fetch_mem_ctrl #(
    parameter int IMEM_WORDS = 256,
    parameter int DMEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] pc,
    input  logic        prog_we,
    input  logic [15:0] prog_addr,
    input  logic [15:0] prog_data,
    output logic [15:0] instr,
    output logic [2:0]  opcode,
    output logic [2:0]  rs,
    output logic [2:0]  rt,
    output logic [2:0]  rd,
    output logic [3:0]  funct,
    output logic [15:0] imm_sext,
    output logic        r_format,
    output logic [2:0]  alu_sel,
    output logic        ainvert,
    output logic        bnegate,
    output logic        alu_illegal,
    input  logic [15:0] dm_addr,
    input  logic [15:0] dm_wdata,
    input  logic        mem_write,
    input  logic        mem_read,
    output logic [15:0] dm_rdata
`ifdef CPU16_ALIGN_CHECK_EN
    ,
    output logic        imem_misalign,
    output logic        dm_misalign
`endif
);

    localparam int IA = $clog2(IMEM_WORDS);
    localparam int DA = $clog2(DMEM_WORDS);

    localparam logic [2:0] SEL_AND = 3'b000;
    localparam logic [2:0] SEL_OR  = 3'b001;
    localparam logic [2:0] SEL_ADD = 3'b010;
    localparam logic [2:0] SEL_XOR = 3'b011;
    localparam logic [2:0] SEL_SLT = 3'b111;

    logic [15:0] imem [IMEM_WORDS];
    logic [15:0] dmem [DMEM_WORDS];

    logic [IA-1:0] fetch_idx;
    logic [IA-1:0] prog_idx;
    logic [DA-1:0] dm_idx;

    // Byte addresses: bit 0 dropped, upper bits discarded so accesses wrap.
    assign fetch_idx = pc[IA:1];
    assign prog_idx  = prog_addr[IA:1];
    assign dm_idx    = dm_addr[DA:1];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{pc, prog_addr, dm_addr};

    always_ff @(posedge clk) begin
        if (rst_n && prog_we) begin
            imem[prog_idx] <= prog_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr <= 16'h0000;
        end else begin
            instr <= imem[fetch_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && mem_write) begin
            dmem[dm_idx] <= dm_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dm_rdata <= 16'h0000;
        end else if (mem_read) begin
            dm_rdata <= dmem[dm_idx];
        end
    end

`ifdef CPU16_ALIGN_CHECK_EN
    // A fetch happens every cycle; data flags only update on an actual access.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_misalign <= 1'b0;
            dm_misalign   <= 1'b0;
        end else begin
            imem_misalign <= pc[0];
            if (mem_read || mem_write) begin
                dm_misalign <= dm_addr[0];
            end
        end
    end
`endif

    assign opcode   = instr[15:13];
    assign rs       = instr[12:10];
    assign rt       = instr[9:7];
    assign rd       = instr[6:4];
    assign funct    = instr[3:0];
    assign imm_sext = {{9{instr[6]}}, instr[6:0]};
    assign r_format = (opcode == 3'b000);

    always_comb begin
        alu_sel     = SEL_ADD;
        ainvert     = 1'b0;
        bnegate     = 1'b0;
        alu_illegal = 1'b0;
        case (opcode)
            3'b000: begin
                case (funct)
                    4'b0000: alu_sel = SEL_ADD;
                    4'b0001: begin
                        alu_sel = SEL_ADD;
                        bnegate = 1'b1;
                    end
                    4'b0010: alu_sel = SEL_AND;
                    4'b0011: alu_sel = SEL_OR;
                    4'b0100: alu_sel = SEL_XOR;
                    4'b0101: begin
                        alu_sel = SEL_AND;
                        ainvert = 1'b1;
                        bnegate = 1'b1;
                    end
                    4'b0110: begin
                        alu_sel = SEL_SLT;
                        bnegate = 1'b1;
                    end
                    default: alu_illegal = 1'b1;
                endcase
            end
            3'b001, 3'b100, 3'b101: alu_sel = SEL_ADD;
            3'b010: alu_sel = SEL_AND;
            3'b011: alu_sel = SEL_OR;
            3'b110: begin
                alu_sel = SEL_ADD;
                bnegate = 1'b1;
            end
            default: alu_illegal = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_cpu16_fetch_mem_ctrl.sv
// Self-checking bench for cpu16_fetch_mem_ctrl: directed vectors, an ALU-control table and random traffic
// compared against array-based memory models. Alignment flags are checked when CPU16_ALIGN_CHECK_EN is defined.
module tb_cpu16_fetch_mem_ctrl;

    localparam int IW = 256;
    localparam int DW = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] pc = '0;
    logic        prog_we = 1'b0;
    logic [15:0] prog_addr = '0;
    logic [15:0] prog_data = '0;
    logic [15:0] instr;
    logic [2:0]  opcode, rs, rt, rd;
    logic [3:0]  funct;
    logic [15:0] imm_sext;
    logic        r_format;
    logic [2:0]  alu_sel;
    logic        ainvert, bnegate, alu_illegal;
    logic [15:0] dm_addr = '0;
    logic [15:0] dm_wdata = '0;
    logic        mem_write = 1'b0;
    logic        mem_read = 1'b0;
    logic [15:0] dm_rdata;
`ifdef CPU16_ALIGN_CHECK_EN
    logic        imem_misalign, dm_misalign;
`endif

    cpu16_fetch_mem_ctrl #(.IMEM_WORDS(IW), .DMEM_WORDS(DW)) dut (
        .clk(clk), .rst_n(rst_n), .pc(pc),
        .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .instr(instr), .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .funct(funct),
        .imm_sext(imm_sext), .r_format(r_format), .alu_sel(alu_sel),
        .ainvert(ainvert), .bnegate(bnegate), .alu_illegal(alu_illegal),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .mem_write(mem_write),
        .mem_read(mem_read), .dm_rdata(dm_rdata)
`ifdef CPU16_ALIGN_CHECK_EN
        , .imem_misalign(imem_misalign), .dm_misalign(dm_misalign)
`endif
    );

    always #5 clk = ~clk;

    int nChecks = 0;
    int nFails  = 0;

    logic [15:0] mImem [IW];
    logic [15:0] mDmem [DW];
    logic [15:0] expInstr = '0;
    logic [15:0] expRdata = '0;
    logic        expImis = 1'b0;
    logic        expDmis = 1'b0;

    typedef struct {
        logic [2:0] op;
        logic [3:0] fn;
        logic [2:0] sel;
        logic       ai;
        logic       bn;
        logic       ill;
    } aluVec_t;
    aluVec_t vecs [23];

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, advance the memory model across the edge, sample 1 ns later.
    task automatic applyStimulus(input logic pw, input logic [15:0] pa, input logic [15:0] pd,
                                 input logic [15:0] pcv, input logic mw, input logic mr,
                                 input logic [15:0] da, input logic [15:0] dw);
        prog_we = pw; prog_addr = pa; prog_data = pd; pc = pcv;
        mem_write = mw; mem_read = mr; dm_addr = da; dm_wdata = dw;
        @(posedge clk);
        if (rst_n) begin
            expInstr = mImem[int'(pcv >> 1) % IW];
            if (mr) expRdata = mDmem[int'(da >> 1) % DW];
            if (pw) mImem[int'(pa >> 1) % IW] = pd;
            if (mw) mDmem[int'(da >> 1) % DW] = dw;
            expImis = pcv[0];
            if (mr || mw) expDmis = da[0];
        end
        #1;
        prog_we = 1'b0; mem_write = 1'b0; mem_read = 1'b0;
    endtask

    task automatic checkDecode(input string tag);
        logic [15:0] v;
        int k;
        v = expInstr & 16'h007F;
        checkOutput({tag, " opcode"}, 16'(opcode), expInstr >> 13);
        checkOutput({tag, " rs"}, 16'(rs), (expInstr >> 10) & 16'd7);
        checkOutput({tag, " rt"}, 16'(rt), (expInstr >> 7) & 16'd7);
        checkOutput({tag, " rd"}, 16'(rd), (expInstr >> 4) & 16'd7);
        checkOutput({tag, " funct"}, 16'(funct), expInstr & 16'd15);
        checkOutput({tag, " imm_sext"}, imm_sext, (v >= 16'd64) ? v - 16'd128 : v);
        checkOutput({tag, " r_format"}, 16'(r_format), 16'((expInstr >> 13) == 16'd0));
        k = ((expInstr >> 13) == 16'd0) ? int'(expInstr & 16'd15) : 15 + int'(expInstr >> 13);
        checkOutput({tag, " alu_sel"}, 16'(alu_sel), 16'(vecs[k].sel));
        checkOutput({tag, " ainvert"}, 16'(ainvert), 16'(vecs[k].ai));
        checkOutput({tag, " bnegate"}, 16'(bnegate), 16'(vecs[k].bn));
        checkOutput({tag, " alu_illegal"}, 16'(alu_illegal), 16'(vecs[k].ill));
    endtask

    initial begin
        // ALU control table: entries 0..15 are R-format functs, 16..22 are I opcodes 1..7.
        for (int i = 0; i < 16; i++) vecs[i] = '{3'd0, 4'(i), 3'b010, 1'b0, 1'b0, 1'b1};
        vecs[0]  = '{3'd0, 4'd0, 3'b010, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{3'd0, 4'd1, 3'b010, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{3'd0, 4'd2, 3'b000, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{3'd0, 4'd3, 3'b001, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{3'd0, 4'd4, 3'b011, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{3'd0, 4'd5, 3'b000, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{3'd0, 4'd6, 3'b111, 1'b0, 1'b1, 1'b0};
        vecs[16] = '{3'd1, 4'd9, 3'b010, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{3'd2, 4'd9, 3'b000, 1'b0, 1'b0, 1'b0};
        vecs[18] = '{3'd3, 4'd9, 3'b001, 1'b0, 1'b0, 1'b0};
        vecs[19] = '{3'd4, 4'd9, 3'b010, 1'b0, 1'b0, 1'b0};
        vecs[20] = '{3'd5, 4'd9, 3'b010, 1'b0, 1'b0, 1'b0};
        vecs[21] = '{3'd6, 4'd9, 3'b010, 1'b0, 1'b1, 1'b0};
        vecs[22] = '{3'd7, 4'd9, 3'b010, 1'b0, 1'b0, 1'b1};

        // Power-on reset, checked between clock edges.
        #1 rst_n = 1'b0;
        #2;
        checkOutput("reset instr", instr, 16'h0000);
        checkOutput("reset dm_rdata", dm_rdata, 16'h0000);
        #9 rst_n = 1'b1;

        // Fill both memories with known random contents.
        for (int i = 0; i < 256; i++)
            applyStimulus(1'b1, 16'(i * 2), 16'($urandom), 16'h0, 1'b1, 1'b0, 16'(i * 2), 16'($urandom));

        // Fetch: same-edge load returns the old word, then the new one.
        mImem[2] = 16'h0000;
        applyStimulus(1'b1, 16'h0004, 16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0);
        applyStimulus(1'b1, 16'h0004, 16'h2C85, 16'h0004, 1'b0, 1'b0, 16'h0, 16'h0);
        checkOutput("fetch read-first", instr, 16'h0000);
        applyStimulus(1'b0, 16'h0, 16'h0, 16'h0004, 1'b0, 1'b0, 16'h0, 16'h0);
        checkOutput("fetch instr", instr, 16'h2C85);
        checkOutput("fetch opcode", 16'(opcode), 16'd1);
        checkOutput("fetch rs", 16'(rs), 16'd3);
        checkOutput("fetch rt", 16'(rt), 16'd1);
        checkOutput("fetch rd", 16'(rd), 16'd0);
        checkOutput("fetch imm_sext", imm_sext, 16'h0005);
        checkOutput("fetch alu_sel", 16'(alu_sel), 16'd2);
        checkOutput("fetch r_format", 16'(r_format), 16'd0);

        // Sign extension and load-address wrap.
        applyStimulus(1'b1, 16'h0006, 16'h207F, 16'h0004, 1'b0, 1'b0, 16'h0, 16'h0);
        applyStimulus(1'b0, 16'h0, 16'h0, 16'h0006, 1'b0, 1'b0, 16'h0, 16'h0);
        checkOutput("sext imm", imm_sext, 16'hFFFF);
        applyStimulus(1'b1, 16'h0200, 16'h1111, 16'h0006, 1'b0, 1'b0, 16'h0, 16'h0);
        applyStimulus(1'b0, 16'h0, 16'h0, 16'h0000, 1'b0, 1'b0, 16'h0, 16'h0);
        checkOutput("imem wrap word0", instr, 16'h1111);
        applyStimulus(1'b0, 16'h0, 16'h0, 16'h0201, 1'b0, 1'b0, 16'h0, 16'h0);
        checkOutput("imem odd pc", instr, 16'h1111);
`ifdef CPU16_ALIGN_CHECK_EN
        checkOutput("imem_misalign set", 16'(imem_misalign), 16'd1);
        applyStimulus(1'b0, 16'h0, 16'h0, 16'h0200, 1'b0, 1'b0, 16'h0, 16'h0);
        checkOutput("imem_misalign clear", 16'(imem_misalign), 16'd0);
`endif

        // ALU control sweep from the table.
        for (int i = 0; i < 23; i++)
            applyStimulus(1'b1, 16'(16'h0100 + 2 * i), {vecs[i].op, 9'h0, vecs[i].fn},
                          16'h0, 1'b0, 1'b0, 16'h0, 16'h0);
        for (int i = 0; i < 23; i++) begin
            applyStimulus(1'b0, 16'h0, 16'h0, 16'(16'h0100 + 2 * i), 1'b0, 1'b0, 16'h0, 16'h0);
            checkOutput($sformatf("alu[%0d] instr", i), instr, {vecs[i].op, 9'h0, vecs[i].fn});
            checkOutput($sformatf("alu[%0d] sel", i), 16'(alu_sel), 16'(vecs[i].sel));
            checkOutput($sformatf("alu[%0d] ainvert", i), 16'(ainvert), 16'(vecs[i].ai));
            checkOutput($sformatf("alu[%0d] bnegate", i), 16'(bnegate), 16'(vecs[i].bn));
            checkOutput($sformatf("alu[%0d] illegal", i), 16'(alu_illegal), 16'(vecs[i].ill));
            checkOutput($sformatf("alu[%0d] r_format", i), 16'(r_format), 16'(i < 16));
        end

        // Data memory: write, read, same-edge read+write, hold, wrap.
        applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0010, 16'hBEEF);
        applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1, 16'h0010, 16'h0);
        checkOutput("dm read", dm_rdata, 16'hBEEF);
        applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b1, 16'h0010, 16'h1234);
        checkOutput("dm read-first", dm_rdata, 16'hBEEF);
        applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1, 16'h0010, 16'h0);
        checkOutput("dm read new", dm_rdata, 16'h1234);
        applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0020, 16'h0);
        checkOutput("dm hold", dm_rdata, 16'h1234);
        applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0210, 16'h5A5A);
        applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1, 16'h0010, 16'h0);
        checkOutput("dm wrap", dm_rdata, 16'h5A5A);

        // Mid-run asynchronous reset; writes attempted during reset must be dropped.
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midreset instr", instr, 16'h0000);
        checkOutput("midreset dm_rdata", dm_rdata, 16'h0000);
        checkOutput("midreset r_format", 16'(r_format), 16'd1);
        checkOutput("midreset alu_sel", 16'(alu_sel), 16'd2);
        checkOutput("midreset bnegate", 16'(bnegate), 16'd0);
        applyStimulus(1'b1, 16'h0004, 16'hAAAA, 16'h0004, 1'b1, 1'b1, 16'h0010, 16'h5555);
        checkOutput("reset held instr", instr, 16'h0000);
        checkOutput("reset held dm_rdata", dm_rdata, 16'h0000);
        #2 rst_n = 1'b1;
        expInstr = '0; expRdata = '0; expImis = 1'b0; expDmis = 1'b0;
        applyStimulus(1'b0, 16'h0, 16'h0, 16'h0004, 1'b0, 1'b1, 16'h0010, 16'h0);
        checkOutput("post-reset imem kept", instr, 16'h2C85);
        checkOutput("post-reset dmem kept", dm_rdata, 16'h5A5A);

`ifdef CPU16_ALIGN_CHECK_EN
        applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 1'b1, 1'b0, 16'h0011, 16'hC0DE);
        checkOutput("dm_misalign set", 16'(dm_misalign), 16'd1);
        applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0013, 16'h0);
        checkOutput("dm_misalign idle hold", 16'(dm_misalign), 16'd1);
        applyStimulus(1'b0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b1, 16'h0010, 16'h0);
        checkOutput("dm misaligned write word8", dm_rdata, 16'hC0DE);
        checkOutput("dm_misalign clear", 16'(dm_misalign), 16'd0);
`endif

        // Random traffic against the array model.
        for (int n = 0; n < 400; n++) begin
            applyStimulus(($urandom % 4) == 0, 16'($urandom), 16'($urandom), 16'($urandom),
                          ($urandom % 3) == 0, ($urandom % 2) == 0,
                          (($urandom % 2) == 0) ? 16'($urandom % 32) : 16'($urandom), 16'($urandom));
            checkOutput("rand instr", instr, expInstr);
            checkOutput("rand dm_rdata", dm_rdata, expRdata);
            checkDecode("rand");
`ifdef CPU16_ALIGN_CHECK_EN
            checkOutput("rand imem_misalign", 16'(imem_misalign), 16'(expImis));
            checkOutput("rand dm_misalign", 16'(dm_misalign), 16'(expDmis));
`endif
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/cpu16_fetch_mem_ctrl.md
Name: cpu16_fetch_mem_ctrl

Overview:
- Memory-and-decode core of the 16-bit single-cycle CPU datapath.
- Contains three parts:
  - a byte-addressed instruction memory with a registered fetch and an instruction-field decode;
  - the ALU-control decoder that turns opcode/funct into ALU select, ainvert and bnegate;
  - a byte-addressed data memory with synchronous write and registered read.
- The register file, ALU and PC adder sit outside this block.

Parameters:
- IMEM_WORDS, 256, instruction memory depth in 16-bit words (power of 2).
- DMEM_WORDS, 256, data memory depth in 16-bit words (power of 2).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pc  in  16  fetch byte address.
- prog_we  in  1  instruction-memory load strobe.
- prog_addr  in  16  load byte address.
- prog_data  in  16  load word.
- instr  out  16  registered fetched instruction.
- opcode  out  3  instr[15:13].
- rs  out  3  instr[12:10].
- rt  out  3  instr[9:7].
- rd  out  3  instr[6:4].
- funct  out  4  instr[3:0].
- imm_sext  out  16  instr[6:0] sign-extended from bit 6.
- r_format  out  1  1 when opcode==0.
- alu_sel  out  3  ALU function select.
- ainvert  out  1  ALU A-invert.
- bnegate  out  1  ALU B-invert and carry-in.
- alu_illegal  out  1  undefined funct/opcode.
- dm_addr  in  16  data byte address.
- dm_wdata  in  16  store data.
- mem_write  in  1  store strobe.
- mem_read  in  1  load strobe.
- dm_rdata  out  16  registered load data.

Behaviour:
- Reset: rst_n low immediately forces instr=0x0000 and dm_rdata=0x0000.
  - With instr=0, decode gives r_format=1, ADD, a NOP-like result.
  - Memory array contents are not reset.
  - All writes are blocked while rst_n is low.
- Addressing: all addresses are byte addresses and bit 0 is ignored.
  - Word index = addr[k:1], with k = log2(depth).
  - Upper bits are discarded, so addresses wrap modulo the memory size.
- Fetch: instr <= imem[pc] on each rising clk. Latency is 1 cycle.
- Load port: prog_we=1 at a rising edge writes prog_data to imem[prog_addr].
  - A same-cycle fetch of the same word returns the old word (read-first).
- Field decode is combinational from instr.
  - imm_sext = {9{instr[6]}, instr[6:0]}.
- ALU control is purely combinational.
  - alu_sel encoding: 000 AND, 001 OR, 010 ADD, 011 XOR, 111 SLT.
  - R-format (opcode 0), by funct:
    - 0000 ADD (010, a0 b0)
    - 0001 SUB (010, a0 b1)
    - 0010 AND (000, 0, 0)
    - 0011 OR (001, 0, 0)
    - 0100 XOR (011, 0, 0)
    - 0101 NOR (000, a1 b1)
    - 0110 SLT (111, a0 b1)
    - any other funct: ADD with alu_illegal=1.
  - I-format, by opcode:
    - 001 ADDI, 100 LW, 101 SW: ADD.
    - 010 ANDI: AND.
    - 011 ORI: OR.
    - 110 BEQ: SUB.
    - 111: ADD with alu_illegal=1.
  - alu_illegal=0 in every other case.
- Data memory:
  - Write: mem_write=1 at a rising edge writes dm_wdata to dmem[dm_addr].
  - Read: mem_read=1 at a rising edge loads dm_rdata with dmem[dm_addr] (read-first on a same-address write).
  - mem_read=0: dm_rdata holds its previous value.
  - mem_read and mem_write together are legal: the read returns the old data and the write commits.
- Reset release is asynchronous. The first fetch and load capture occur at the first rising edge with rst_n high.

Optional Feature:
- Macro: CPU16_ALIGN_CHECK_EN.
- When defined, the block adds two outputs, imem_misalign and dm_misalign, each 1 bit and registered.
  - Each is set at the rising edge where its memory access occurs with address bit 0 = 1:
    - imem_misalign: any fetch with pc[0]=1.
    - dm_misalign: mem_read or mem_write with dm_addr[0]=1.
  - Each is cleared at the next access with an aligned address, and by reset.
  - The access itself still proceeds with bit 0 ignored.
- When not defined, these ports do not exist and misaligned addresses are silently aligned.

Test Plan:
- Reset: rst_n=0 mid-run -> instr=0x0000, dm_rdata=0x0000 without a clock edge; r_format=1, alu_sel=010, bnegate=0.
- Fetch: load imem byte 0x0004 with 0x2C85 via prog_we, set pc=0x0004.
  - One edge later instr=0x2C85.
  - Decode: opcode=001, rs=011, rt=001, rd=000, imm_sext=0x0005, alu_sel=010, r_format=0.
- Immediate sign extension: instruction 0x207F -> imm_sext=0xFFFF.
  - Also check the wrap: prog_addr=0x0200 with IMEM_WORDS=256 overwrites word 0.
- ALU control sweep: opcode 0 with funct 0..15 and every I opcode -> the table values.
  - funct=0101 gives 000/a1/b1; funct=1001 gives alu_illegal=1; opcode 110 gives 010/b1.
- Data memory:
  - Write 0xBEEF to 0x0010, then read -> dm_rdata=0xBEEF after 1 edge.
  - Same-edge read+write 0x1234 to 0x0010 -> dm_rdata=0xBEEF, next read gives 0x1234.
  - mem_read=0 -> dm_rdata holds.
- With CPU16_ALIGN_CHECK_EN: dm_addr=0x0011 write -> dm_misalign=1 and dmem word 8 is written; the next aligned access clears it.
